imm_encoder: RTL
================

# imm_encoder

Pipelined RISC-V instruction assembler: the inverse of the immediate-extraction path. Accepts decoded fields (format, opcode, registers, functs, 32-bit immediate) over a valid/ready handshake. Scatters the immediate into the format-specific bit positions and emits the 32-bit instruction word with a write address. Used by the boot/program loader and by the self-test generator to fill instruction memory. Flags immediates that the chosen format cannot represent.

## Interface
- ADDR_W, 32, width of the output address counter
- BASE_ADDR, 32'h0000_0000, address assigned to the first instruction after reset or clear
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous; reloads address counter to BASE_ADDR, zeroes err_count
- in_valid  in  1  field bundle valid
- in_ready  out  1  buffer can accept (registered-state only, no combinational path from out_ready)
- in_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
- in_opcode  in  7  placed at [6:0] unchanged
- in_rd, in_rs1, in_rs2  in  5 each
- in_funct3  in  3;  in_funct7  in  7 (R only)
- in_imm  in  32  signed byte-offset/immediate value
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head
- out_instr  out  32  assembled instruction
- out_addr  out  ADDR_W  address for out_instr
- out_err  out  1  head entry immediate or format illegal
- err_count  out  8  saturating count of accepted erroneous bundles

## Operation
- Field placement: R {funct7,rs2,rs1,f3,rd,op}; I {imm[11:0],rs1,f3,rd,op}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; U {imm[31:12],rd,op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
- Unused fields ignored (e.g. rd in S/B, funct7 outside R).
- Legality, err=1 when: I/S imm outside [-2048,2047]; B outside [-4096,4094] or imm[0]=1; J outside [-1048576,1048574] or imm[0]=1; U imm[11:0]!=0; fmt 6/7. R never errs.
- Erroneous bundle is still emitted, fields truncated as above; for fmt 6/7, out_instr=32'h0000_0013 (nop).
- Buffer: 2-entry FIFO of {instr, addr, err}. in_ready = (count!=2). out_valid = (count!=0). Push on in_valid&&in_ready; pop on out_valid&&out_ready; simultaneous push/pop at count 1 keeps count 1.
- Address: counter addr_q assigned to each pushed entry, then addr_q += 4, wraps modulo 2^ADDR_W.
- clear with push in the same cycle: entry gets BASE_ADDR, addr_q becomes BASE_ADDR+4. clear does not flush the FIFO.
- err_count increments on push of err entry, saturates at 255. clear+erroneous push gives 1.

## Timing
- Reset: count=0, out_valid=0, in_ready=1, out_instr=0, out_addr=0, out_err=0, err_count=0, addr_q=BASE_ADDR.
- Latency: push in cycle N gives out_valid in N+1 with that entry at head (if FIFO was empty).
- Throughput 1/cycle when out_ready held high.
- out_* stable while out_valid && !out_ready.
- Reset mid-stream drops all buffered entries. No output is produced until new pushes.

## Structure
- Shared package riscv_pkg: fmt_e enum (FMT_R..FMT_J), opcode constants, NOP_INSTR, immediate range constants.
- Sub-module imm_pack (combinational: fmt, fields, imm to instr, err).
- FIFO and counters stay in the top.

## Test plan
- I, op 0x13, rd1, rs1 0, f3 0, imm 5 -> out_instr 0x00500093, addr 0x0, err 0. Next push with imm -1, rd 0 -> 0xFFF00013, addr 0x4.
- S, op 0x23, rs1 1, rs2 2, f3 2, imm 4 -> 0x0020A223. B, op 0x63, all regs 0, imm 8 -> 0x00000463. J, op 0x6F, rd 0, imm 8 -> 0x0080006F.
- U, op 0x37, rd 5, imm 0x12345000 -> 0x123452B7, err 0. Same with imm 0x12345001 -> err 1, err_count 1.
- B imm 3, I imm 2048, fmt 7 -> each err 1; fmt 7 yields 0x00000013. 300 erroneous pushes -> err_count 255.
- out_ready low: 2 pushes make in_ready 0 and the third is held. Head stays stable. Raising out_ready drains in order with addresses 0,4,8.
- clear coincident with push -> that entry addr BASE_ADDR, next addr BASE_ADDR+4. Asserting rst_n low mid-stream -> out_valid 0 immediately, in_ready 1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding definitions: instruction formats, opcodes and
// the signed ranges each immediate format can represent.
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_OPIMM  = 7'h13;
  localparam logic [6:0] OP_OP     = 7'h33;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int signed IMM_I_MIN = -2048;
  localparam int signed IMM_I_MAX = 2047;
  localparam int signed IMM_B_MIN = -4096;
  localparam int signed IMM_B_MAX = 4094;
  localparam int signed IMM_J_MIN = -1048576;
  localparam int signed IMM_J_MAX = 1048574;

endpackage

// File: rtl/imm_pack.sv
// Combinational instruction assembler: scatters the immediate into the
// format's bit positions and flags values the format cannot hold.
module imm_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  logic signed [31:0] simm;
  logic               fits_i;
  logic               fits_b;
  logic               fits_j;

  assign simm   = $signed(imm);
  assign fits_i = (simm >= IMM_I_MIN) && (simm <= IMM_I_MAX);
  assign fits_b = (simm >= IMM_B_MIN) && (simm <= IMM_B_MAX) && !imm[0];
  assign fits_j = (simm >= IMM_J_MIN) && (simm <= IMM_J_MAX) && !imm[0];

  always_comb begin
    instr = NOP_INSTR;
    err   = 1'b1;
    case (fmt)
      FMT_R: begin
        instr = {funct7, rs2, rs1, funct3, rd, opcode};
        err   = 1'b0;
      end
      FMT_I: begin
        instr = {imm[11:0], rs1, funct3, rd, opcode};
        err   = !fits_i;
      end
      FMT_S: begin
        instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err   = !fits_i;
      end
      FMT_B: begin
        instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err   = !fits_b;
      end
      FMT_U: begin
        instr = {imm[31:12], rd, opcode};
        err   = (imm[11:0] != 12'd0);
      end
      FMT_J: begin
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err   = !fits_j;
      end
      default: begin
        // Unknown formats still occupy a slot so addresses stay contiguous.
        instr = NOP_INSTR;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Instruction word generator: assembles field bundles, tags each with a
// sequential write address and buffers them in a 2-entry FIFO.
module imm_encoder
  import riscv_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_count
);

  logic [31:0]       pack_instr;
  logic              pack_err;

  logic [31:0]       instr_mem [2];
  logic [ADDR_W-1:0] addr_mem  [2];
  logic [1:0]        err_mem;

  logic              wr_ptr_reg;
  logic              rd_ptr_reg;
  logic [1:0]        count_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [7:0]        err_count_reg;

  logic              push;
  logic              pop;
  logic [1:0]        wr_en;
  logic [ADDR_W-1:0] entry_addr;
  logic [7:0]        err_base;

  imm_pack u_pack (
    .fmt    (in_fmt),
    .opcode (in_opcode),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .imm    (in_imm),
    .instr  (pack_instr),
    .err    (pack_err)
  );

  assign in_ready   = (count_reg != 2'd2);
  assign out_valid  = (count_reg != 2'd0);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  // A clear in the same cycle as a push restarts numbering at that entry.
  assign entry_addr = clear ? BASE_ADDR : addr_reg;
  assign err_base   = clear ? 8'd0 : err_count_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_wr_en
      assign wr_en[gi] = push && (wr_ptr_reg == gi[0]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        instr_mem[i] <= '0;
        addr_mem[i]  <= '0;
      end
      err_mem <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wr_en[i]) begin
          instr_mem[i] <= pack_instr;
          addr_mem[i]  <= entry_addr;
          err_mem[i]   <= pack_err;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= 1'b0;
      rd_ptr_reg    <= 1'b0;
      count_reg     <= 2'd0;
      addr_reg      <= BASE_ADDR;
      err_count_reg <= 8'd0;
    end else begin
      if (push) wr_ptr_reg <= !wr_ptr_reg;
      if (pop)  rd_ptr_reg <= !rd_ptr_reg;

      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase

      if (push)       addr_reg <= entry_addr + ADDR_W'(4);
      else if (clear) addr_reg <= BASE_ADDR;

      if (push && pack_err && (err_base != 8'hFF)) err_count_reg <= err_base + 8'd1;
      else                                         err_count_reg <= err_base;
    end
  end

  assign out_instr = instr_mem[rd_ptr_reg];
  assign out_addr  = addr_mem[rd_ptr_reg];
  assign out_err   = err_mem[rd_ptr_reg];
  assign err_count = err_count_reg;

endmodule
